// File: rtl/mult_stream_buffer_pkg.sv
// ============================================================================
// mult_stream_pkg : shared widths and helpers for the multiplier stream buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_stream_pkg;

  localparam int DEF_IN_W = 8;
  localparam int DATA_W   = 2 * DEF_IN_W;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that a full FIFO is distinguishable from empty.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic ext_fill(input logic msb, input bit is_signed);
    return msb & is_signed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_stream_buffer_if.sv
// ============================================================================
// mult_stream_buffer_if : producer/consumer bus of the multiplier stream buffer
// Rev 1.0
// ============================================================================
`default_nettype none

interface mult_stream_buffer_if
  import mult_stream_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int DEPTH_IN  = 16,
  parameter int DEPTH_OUT = 16
);

  logic                           wr;
  logic [2*IN_W-1:0]              din;
  logic                           stop;
  logic                           rd;
  logic [2*IN_W-1:0]              dout;
  logic                           valid;
  logic                           empty;
  logic                           first_full;
  logic                           second_full;
  logic [cnt_w(DEPTH_IN)-1:0]     in_count;
  logic [cnt_w(DEPTH_OUT)-1:0]    out_count;
  logic                           ovf;
  logic                           unf;

  modport master (
    output wr, din, stop, rd,
    input  dout, valid, empty, first_full, second_full,
           in_count, out_count, ovf, unf
  );

  modport slave (
    input  wr, din, stop, rd,
    output dout, valid, empty, first_full, second_full,
           in_count, out_count, ovf, unf
  );

endinterface

`default_nettype wire

// File: rtl/mult_stream_buffer_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with first-word-fall-through head and count
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import mult_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int c_ptr_w = ptr_w(DEPTH);
  localparam int c_cnt_w = cnt_w(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  // A push while full is refused even if a pop happens in the same cycle.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mult_stream_buffer.sv
// ============================================================================
// mult_stream_buffer : input FIFO -> pipelined multiplier -> output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_stream_buffer
  import mult_stream_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int DEPTH_IN  = 16,
  parameter int DEPTH_OUT = 16,
  parameter int MULT_LAT  = 2,
  parameter int SIGNED    = 0
)
(
  input  logic                 clk,
  input  logic                 rst,
  mult_stream_buffer_if.slave  bus
);

  localparam int c_data_w = 2 * IN_W;

  logic [c_data_w-1:0]         w_in_head;
  logic [cnt_w(DEPTH_IN)-1:0]  w_in_count;
  logic                        w_in_full;
  logic                        w_in_empty;
  logic [c_data_w-1:0]         w_out_head;
  logic [cnt_w(DEPTH_OUT)-1:0] w_out_count;
  logic                        w_out_full;
  logic                        w_out_empty;

  logic [IN_W-1:0]             w_op_a;
  logic [IN_W-1:0]             w_op_b;
  logic [c_data_w-1:0]         w_a_ext;
  logic [c_data_w-1:0]         w_b_ext;
  logic [c_data_w-1:0]         w_prod;
  logic [31:0]                 w_used;
  logic                        w_issue;

  logic [c_data_w-1:0]         r_stage_data [MULT_LAT];
  logic [MULT_LAT-1:0]         r_stage_vld;
  logic [c_data_w-1:0]         r_dout;
  logic                        r_valid;
  logic                        r_ovf;
  logic                        r_unf;

  sync_fifo #(.WIDTH(c_data_w), .DEPTH(DEPTH_IN)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr),
    .push_data (bus.din),
    .pop       (w_issue),
    .head      (w_in_head),
    .count     (w_in_count),
    .full      (w_in_full),
    .empty     (w_in_empty)
  );

  assign w_op_a  = w_in_head[c_data_w-1:IN_W];
  assign w_op_b  = w_in_head[IN_W-1:0];
  // Extending both operands to full product width lets one modular multiply cover both modes.
  assign w_a_ext = {{IN_W{ext_fill(w_op_a[IN_W-1], SIGNED != 0)}}, w_op_a};
  assign w_b_ext = {{IN_W{ext_fill(w_op_b[IN_W-1], SIGNED != 0)}}, w_op_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Credit: every stored or in-flight product owns an output slot; the exiting stage still counts.
  always_comb begin
    w_used = 32'(w_out_count);
    for (int i = 0; i < MULT_LAT; i++) begin
      w_used = w_used + 32'(r_stage_vld[i]);
    end
    w_issue = !w_in_empty && !bus.stop && (w_used < 32'(DEPTH_OUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_vld <= '0;
    end else begin
      r_stage_vld[0] <= w_issue;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_stage_vld[i] <= r_stage_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_stage_data[0] <= w_prod;
    for (int i = 1; i < MULT_LAT; i++) begin
      r_stage_data[i] <= r_stage_data[i-1];
    end
  end

  sync_fifo #(.WIDTH(c_data_w), .DEPTH(DEPTH_OUT)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_stage_vld[MULT_LAT-1]),
    .push_data (r_stage_data[MULT_LAT-1]),
    .pop       (bus.rd),
    .head      (w_out_head),
    .count     (w_out_count),
    .full      (w_out_full),
    .empty     (w_out_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= bus.rd && !w_out_empty;
      if (bus.rd && !w_out_empty) r_dout <= w_out_head;
      if (bus.wr && w_in_full)    r_ovf  <= 1'b1;
      if (bus.rd && w_out_empty)  r_unf  <= 1'b1;
    end
  end

  assign bus.dout        = r_dout;
  assign bus.valid       = r_valid;
  assign bus.empty       = w_out_empty;
  assign bus.first_full  = w_in_full;
  assign bus.second_full = w_out_full;
  assign bus.in_count    = w_in_count;
  assign bus.out_count   = w_out_count;
  assign bus.ovf         = r_ovf;
  assign bus.unf         = r_unf;

endmodule

`default_nettype wire
